// File: rtl/key_switch_in_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_switch_in_if
// Register bus between a bus master and the key/switch input block.
// Rev 1.0
// ---------------------------------------------------------------------------
interface key_switch_in_if;
  logic [31:0] WBwritadress;
  logic [31:0] WBwritdata;
  logic        KEYWrite;
  logic        KEYRead;
  logic [31:0] KEY_Read_data;

  modport master (
    output WBwritadress,
    output WBwritdata,
    output KEYWrite,
    output KEYRead,
    input  KEY_Read_data
  );

  modport slave (
    input  WBwritadress,
    input  WBwritdata,
    input  KEYWrite,
    input  KEYRead,
    output KEY_Read_data
  );
endinterface
`default_nettype wire

// File: rtl/key_switch_in.sv
`default_nettype none
// ---------------------------------------------------------------------------
// key_switch_in
// Synchronizes and debounces 8 slide switches and 4 push buttons, latches
// button press events in a sticky W1C register and raises a level interrupt.
// Registers: STATUS at BASE_ADDR, EDGE at +4, CTRL at +8.
// Rev 1.0
// ---------------------------------------------------------------------------
module key_switch_in #(
  parameter int          DB_COUNT  = 100000,
  parameter logic [31:0] BASE_ADDR = 32'h40000014
) (
  input  logic            clk,
  input  logic            reset,
  key_switch_in_if.slave  bus,
  input  logic [7:0]      sw,
  input  logic [3:0]      btn,
  output logic            irq
);

  localparam int          N_IN        = 12;
  localparam int          CW          = 20;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DB_COUNT - 1);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR;
  localparam logic [31:0] EDGE_ADDR   = BASE_ADDR + 32'd4;
  localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + 32'd8;

  logic [N_IN-1:0] raw;
  logic [N_IN-1:0] sync1;
  logic [N_IN-1:0] sync2;
  logic [N_IN-1:0] db;
  logic [3:0]      btn_prev;
  logic [3:0]      rise;
  logic [3:0]      edge_flags;
  logic            irq_en;
  logic [31:0]     read_data;
  logic [31:0]     read_mux;
  logic            hit_status;
  logic            hit_edge;
  logic            hit_ctrl;
  logic            unused_wdata;

  // Buttons occupy the upper nibble so STATUS is a straight copy of db.
  assign raw = {btn, sw};

  // Two-flop synchronizer on every raw input bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < N_IN; i++) begin : g_bit
    logic [CW-1:0] cnt;
    logic          state;

    // Per-bit debounce: follow the synchronized input only after it has
    // disagreed with the debounced state for DB_COUNT consecutive cycles.
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cnt   <= '0;
        state <= 1'b0;
      end else if (sync2[i] == state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        state <= sync2[i];
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign db[i] = state;
  end

  // Full 32-bit address compare so no register aliases elsewhere.
  assign hit_status = (bus.WBwritadress == STATUS_ADDR);
  assign hit_edge   = (bus.WBwritadress == EDGE_ADDR);
  assign hit_ctrl   = (bus.WBwritadress == CTRL_ADDR);

  // Only the debounced buttons produce press events; releases are ignored.
  assign rise = db[11:8] & ~btn_prev;

  // Upper write-data bits carry no register fields.
  assign unused_wdata = ^bus.WBwritdata[31:4];

  // Read-data source for the addressed register; unmapped reads give zero.
  always_comb begin
    read_mux = 32'h0;
    if (hit_status) begin
      read_mux = {20'b0, db};
    end else if (hit_edge) begin
      read_mux = {28'b0, edge_flags};
    end else if (hit_ctrl) begin
      read_mux = {31'b0, irq_en};
    end
  end

  // Sticky edge flags, interrupt enable, interrupt and registered read data.
  // A new press always survives a simultaneous W1C of the same bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_prev   <= '0;
      edge_flags <= '0;
      irq_en     <= 1'b0;
      irq        <= 1'b0;
      read_data  <= '0;
    end else begin
      btn_prev <= db[11:8];
      irq      <= irq_en & (|edge_flags);
      if (bus.KEYWrite && hit_edge) begin
        edge_flags <= (edge_flags & ~bus.WBwritdata[3:0]) | rise;
      end else begin
        edge_flags <= edge_flags | rise;
      end
      if (bus.KEYWrite && hit_ctrl) begin
        irq_en <= bus.WBwritdata[0];
      end
      if (bus.KEYRead && !bus.KEYWrite) begin
        read_data <= read_mux;
      end
    end
  end

  assign bus.KEY_Read_data = read_data;

endmodule
`default_nettype wire

// File: tb/tb_key_switch_in.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_key_switch_in
// Scoreboard bench: a cycle-level reference model pushes the expected
// irq/read-data pair every clock; a monitor pops and compares after the edge.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_key_switch_in;

  localparam int          DB   = 4;
  localparam logic [31:0] BASE = 32'h40000014;
  localparam logic [31:0] A_ST = BASE;
  localparam logic [31:0] A_ED = BASE + 32'd4;
  localparam logic [31:0] A_CT = BASE + 32'd8;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] sw    = 8'h00;
  logic [3:0] btn   = 4'h0;
  logic       irq;

  key_switch_in_if bus();

  key_switch_in #(.DB_COUNT(DB), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .sw    (sw),
    .btn   (btn),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Scoreboard entries: {irq, KEY_Read_data}
  logic [32:0] expq[$];

  // Reference model state
  logic [11:0] rawq[$];   // raw samples still travelling through the synchronizer
  logic [11:0] win[$];    // last DB synchronized samples
  logic [11:0] mdb;
  logic [3:0]  mbprev;
  logic [3:0]  medge;
  logic        men;
  logic        mirq;
  logic [31:0] mrd;

  function automatic logic [31:0] model_reg(input logic [31:0] a);
    if (a == A_ST) return {20'b0, mdb};
    if (a == A_ED) return {28'b0, medge};
    if (a == A_CT) return {31'b0, men};
    return 32'h0;
  endfunction

  task automatic model_reset();
    rawq.delete();
    rawq.push_back(12'h0);
    rawq.push_back(12'h0);
    win.delete();
    for (int i = 0; i < DB; i++) win.push_back(12'h0);
    mdb    = '0;
    mbprev = '0;
    medge  = '0;
    men    = 1'b0;
    mirq   = 1'b0;
    mrd    = '0;
  endtask

  // Reference model: a debounced bit flips once the last DB synchronized
  // samples all hold the opposite value; a debounced press sets EDGE next cycle.
  always @(posedge clk) begin : model
    logic [11:0] samp, all1, all0;
    logic [3:0]  rise, clr;
    logic [31:0] rdv;
    logic        en_next;
    if (!reset) begin
      model_reset();
    end else begin
      rawq.push_back({btn, sw});
      samp = rawq[0];
      rawq.delete(0);
      win.push_back(samp);
      win.delete(0);
      all1 = '1;
      all0 = '1;
      foreach (win[i]) begin
        all1 &= win[i];
        all0 &= ~win[i];
      end
      rdv     = mrd;
      clr     = 4'h0;
      en_next = men;
      if (bus.KEYRead && !bus.KEYWrite) rdv = model_reg(bus.WBwritadress);
      if (bus.KEYWrite && bus.WBwritadress == A_ED) clr = bus.WBwritdata[3:0];
      if (bus.KEYWrite && bus.WBwritadress == A_CT) en_next = bus.WBwritdata[0];
      rise   = mdb[11:8] & ~mbprev;
      mirq   = men & (|medge);
      medge  = (medge & ~clr) | rise;
      men    = en_next;
      mbprev = mdb[11:8];
      mdb    = all1 | (mdb & ~all0);
      mrd    = rdv;
    end
    expq.push_back({mirq, mrd});
  end

  // Monitor: compare DUT outputs against the oldest expectation each cycle.
  always @(posedge clk) begin : monitor
    logic [32:0] e;
    #1;
    vectors++;
    if (expq.size() == 0) begin
      miscompares++;
      $display("FAIL scoreboard_empty: got no expectation at %0t", $time);
    end else begin
      e = expq.pop_front();
      if (irq !== e[32]) begin
        miscompares++;
        $display("FAIL irq @%0t: got %b expected %b", $time, irq, e[32]);
      end
      vectors++;
      if (bus.KEY_Read_data !== e[31:0]) begin
        miscompares++;
        $display("FAIL read_data @%0t: got %h expected %h", $time, bus.KEY_Read_data, e[31:0]);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a);
    bus.WBwritadress = a;
    bus.KEYRead      = 1'b1;
    @(negedge clk);
    bus.KEYRead      = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.WBwritadress = a;
    bus.WBwritdata   = d;
    bus.KEYWrite     = 1'b1;
    @(negedge clk);
    bus.KEYWrite     = 1'b0;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return A_ST;
      1:       return A_ED;
      2:       return A_CT;
      3:       return BASE + 32'd12;
      4:       return 32'h40000020;
      default: return A_ED ^ 32'h10000000;
    endcase
  endfunction

  initial begin
    int b;
    bus.WBwritadress = '0;
    bus.WBwritdata   = '0;
    bus.KEYWrite     = 1'b0;
    bus.KEYRead      = 1'b0;

    // Reset with switches high, then release and read STATUS.
    sw = 8'hFF;
    idle(3);
    reset = 1'b1;
    sw    = 8'hA5;
    idle(10);
    rd(A_ST);

    // Two-cycle glitch on btn[0] must not register.
    btn[0] = 1'b1;
    idle(2);
    btn[0] = 1'b0;
    idle(10);
    rd(A_ST);
    rd(A_ED);

    // Press, W1C, release.
    btn[2] = 1'b1;
    idle(10);
    rd(A_ED);
    wr(A_ED, 32'h4);
    rd(A_ED);
    btn[2] = 1'b0;
    idle(10);
    rd(A_ED);

    // Interrupt enable, set and clear.
    wr(A_CT, 32'h1);
    btn[1] = 1'b1;
    idle(10);
    wr(A_ED, 32'h2);
    idle(3);
    btn[1] = 1'b0;
    btn[0] = 1'b1;
    idle(10);
    wr(A_CT, 32'h0);
    idle(3);
    btn[0] = 1'b0;
    wr(A_ED, 32'hF);
    idle(8);

    // W1C of edge[3] in the exact cycle it sets (2 + DB + 1 edges after press).
    btn[3] = 1'b1;
    idle(2 + DB);
    wr(A_ED, 32'h8);
    rd(A_ED);
    btn[3] = 1'b0;
    wr(A_ED, 32'hF);
    idle(8);

    // Unmapped read, then simultaneous read and write.
    rd(A_ED + 32'd4);
    rd(32'h40000020);
    rd(A_CT);
    bus.WBwritadress = A_ED;
    bus.WBwritdata   = 32'h0;
    bus.KEYWrite     = 1'b1;
    bus.KEYRead      = 1'b1;
    @(negedge clk);
    bus.KEYWrite     = 1'b0;
    bus.KEYRead      = 1'b0;

    // Reset while btn[0] debounce count is 2.
    wr(A_CT, 32'h1);
    btn[0] = 1'b1;
    idle(4);
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    idle(2 + DB + 2);
    rd(A_ED);
    rd(A_ST);

    // Randomized traffic.
    for (int it = 0; it < 400; it++) begin
      case ($urandom_range(0, 6))
        0: begin sw = 8'($urandom); idle($urandom_range(1, 8)); end
        1: begin btn = 4'($urandom); idle($urandom_range(1, 8)); end
        2: begin b = $urandom_range(0, 3); btn[b] = ~btn[b]; idle($urandom_range(1, 8)); end
        3: rd(pick_addr());
        4: wr(pick_addr(), $urandom);
        5: rd(A_ED);
        default: idle($urandom_range(1, 6));
      endcase
      if (it == 200) begin
        reset = 1'b0;
        idle(2);
        reset = 1'b1;
      end
    end

    idle(12);
    rd(A_ST);
    rd(A_ED);
    rd(A_CT);
    idle(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/key_switch_in.md
KEY_SWITCH_IN -- requirements
Module: key_switch_in

Interface
REQ-001 SHALL have parameter DB_COUNT, default 100000, meaning the stable cycles required before a debounced input changes (legal range 2 to 2^20-1).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h40000014, meaning the address of the STATUS register; EDGE is at BASE_ADDR+4 and CTRL at BASE_ADDR+8.
REQ-003 Ports, one per line:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- WBwritadress  in  32  bus address.
- WBwritdata  in  32  bus write data.
- KEYWrite  in  1  write strobe.
- KEYRead  in  1  read strobe.
- sw  in  8  raw slide switches, asynchronous to clk.
- btn  in  4  raw push buttons, asynchronous to clk, 1 = pressed.
- KEY_Read_data  out  32  registered read data.
- irq  out  1  interrupt request, level.

Function
REQ-004 Each of the 12 raw bits SHALL pass through a two-flop synchronizer before any other use.
REQ-005 Each synchronized bit SHALL have its own debounce counter and debounced state.
- Counter clears when the synchronized value equals the debounced state.
- Otherwise the counter increments.
- When the counter reaches DB_COUNT-1 while the values still differ, the debounced state takes the synchronized value and the counter clears.
REQ-006 A glitch shorter than DB_COUNT cycles after synchronization SHALL NOT change the debounced state.
REQ-007 A rising edge of a debounced btn bit SHALL set the matching sticky EDGE bit in the next cycle.
- Falling edges have no effect on EDGE.
- sw bits do not generate edges.
REQ-008 STATUS (read-only) SHALL read as {20'b0, btn_db[3:0], sw_db[7:0]}; writes to it are ignored.
REQ-009 EDGE SHALL read as {28'b0, edge[3:0]}.
- A write clears every edge bit whose WBwritdata[3:0] bit is 1 (write-1-to-clear).
REQ-010 CTRL SHALL read as {31'b0, irq_en}; a write loads irq_en from WBwritdata[0].
REQ-011 irq SHALL be registered and equal irq_en AND (OR of edge[3:0]) as of the previous cycle.
REQ-012 A read SHALL be registered. When KEYRead=1 and KEYWrite=0, KEY_Read_data takes the addressed register value on the next clk edge.
REQ-013 A read of any unmapped address SHALL load KEY_Read_data with 32'h00000000.
REQ-014 When KEYRead=0, or when KEYWrite=1, KEY_Read_data SHALL hold its value.
- Write has priority over read.
- A write to an unmapped address changes no state.
REQ-015 If an edge set and a W1C clear hit the same bit in the same cycle, the set SHALL win.
REQ-016 A read of EDGE in the same cycle as a new edge set SHALL return the pre-set value; the bit is visible on the following read.
REQ-017 Addresses SHALL be decoded on the full 32 bits; no aliasing.

Reset
REQ-018 While reset=0, all of the following SHALL be 0 asynchronously:
- synchronizer flops, debounce counters, debounced states.
- edge[3:0], irq_en, irq, KEY_Read_data.
REQ-019 After reset deasserts, inputs held at 1 SHALL appear in STATUS after 2 synchronizer cycles plus DB_COUNT cycles.
- An input held at 1 through reset produces an EDGE bit once debounced, if it is a btn.
REQ-020 Reset asserted mid-debounce SHALL discard the partial count; no edge is recorded.

Verification (DB_COUNT=4 for simulation)
REQ-021 Reset: drive reset=0 with sw=8'hFF -> KEY_Read_data=0, irq=0. Release, hold sw=8'hA5, wait 10 cycles, read BASE_ADDR -> 32'h000000A5.
REQ-022 Glitch: pulse btn[0] high for 2 cycles, wait 10, read STATUS -> bit8=0; read EDGE -> 0.
REQ-023 Press and W1C: hold btn[2]=1 for 10 cycles, read EDGE -> 32'h4. Write EDGE with 32'h4, read EDGE -> 0. Release btn[2] -> EDGE stays 0.
REQ-024 IRQ: write CTRL=1, press btn[1] -> irq=1 one cycle after edge[1] sets. Write EDGE=32'h2 -> irq=0 one cycle after the clear. Write CTRL=0 with an edge pending -> irq=0.
REQ-025 Collision and unmapped access:
- W1C of edge[3] in the exact cycle edge[3] sets -> EDGE reads 32'h8.
- Read of 32'h40000020 -> 0.
- Simultaneous KEYWrite and KEYRead -> KEY_Read_data unchanged.
REQ-026 Reset mid-operation: assert reset while btn[0]'s count is 2 -> counters cleared. After release, btn[0] still high is debounced from zero and sets edge[0] exactly 2+DB_COUNT+1 cycles later.
